// File: rtl/pc_npc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_npc_sequencer
//  Description : PC/nPC sequencer with delayed-branch annul handling and
//                single-cycle trap entry. Three-state control: INIT, RUN, TRAP.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_npc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INC      = WIDTH'(4),
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'('h80)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             le,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] ta,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             annul,
  input  logic             trap_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             squash,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] saved_pc,
  output logic [WIDTH-1:0] saved_npc,
  output logic             trap_ack
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] seq_addr;     // npc + INC, wraps modulo 2^WIDTH
  logic [WIDTH-1:0] target;       // selected control-transfer target
  logic [WIDTH-1:0] target_inc;   // target + INC for annulled taken transfers

  // Address arithmetic shared by all RUN-state update paths
  always_comb begin
    seq_addr   = npc + INC;
    target     = (sel == 2'b01) ? ta : alu_out;
    target_inc = target + INC;
  end

  // Control FSM with all outputs registered; reset is asynchronous on clr low
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_INIT;
      pc          <= RESET_PC;
      npc         <= RESET_PC + INC;
      squash      <= 1'b0;
      fetch_valid <= 1'b0;
      trap_ack    <= 1'b0;
      saved_pc    <= '0;
      saved_npc   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          // One idle cycle after reset; inputs are not observed here
          state       <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_TRAP: begin
          // Trap vector already loaded; a held trap_req re-traps from RUN
          state    <= S_RUN;
          trap_ack <= 1'b0;
        end
        S_RUN: begin
          trap_ack <= 1'b0;
          if (trap_req) begin
            saved_pc  <= pc;
            saved_npc <= npc;
            pc        <= TRAP_VEC;
            npc       <= TRAP_VEC + INC;
            squash    <= 1'b0;
            trap_ack  <= 1'b1;
            state     <= S_TRAP;
          end else if (le) begin
            case (sel)
              2'b00: begin
                // Sequential; an annulled untaken branch squashes the delay slot
                pc     <= npc;
                npc    <= seq_addr;
                squash <= annul;
              end
              2'b01, 2'b10: begin
                if (annul) begin
                  // Taken and annulled: skip the delay slot entirely
                  pc  <= target;
                  npc <= target_inc;
                end else begin
                  pc  <= npc;
                  npc <= target;
                end
                squash <= 1'b0;
              end
              default: begin
                // Hold: pc/npc unchanged, annul ignored
                squash <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_npc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_npc_sequencer
//  Description : Self-checking bench for pc_npc_sequencer (32-bit and 8-bit
//                instances driven in lock-step against a behavioural model).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_npc_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        le = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] ta = '0;
  logic [31:0] alu_out = '0;
  logic        annul = 1'b0;
  logic        trap_req = 1'b0;

  logic [31:0] pc, npc, saved_pc, saved_npc;
  logic        squash, fetch_valid, trap_ack;
  logic [7:0]  pc8, npc8, saved_pc8, saved_npc8;
  logic        squash8, fetch_valid8, trap_ack8;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain architectural values plus two phase flags
  logic [31:0] m_pc, m_npc, m_spc, m_snpc;
  logic        m_squash, m_fv, m_ack;
  bit          m_started, m_in_trap;

  pc_npc_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .le(le), .sel(sel), .ta(ta), .alu_out(alu_out),
    .annul(annul), .trap_req(trap_req), .pc(pc), .npc(npc), .squash(squash),
    .fetch_valid(fetch_valid), .saved_pc(saved_pc), .saved_npc(saved_npc),
    .trap_ack(trap_ack)
  );

  pc_npc_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .le(le), .sel(sel), .ta(ta[7:0]), .alu_out(alu_out[7:0]),
    .annul(annul), .trap_req(trap_req), .pc(pc8), .npc(npc8), .squash(squash8),
    .fetch_valid(fetch_valid8), .saved_pc(saved_pc8), .saved_npc(saved_npc8),
    .trap_ack(trap_ack8)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h4; m_spc = '0; m_snpc = '0;
    m_squash = 0; m_fv = 0; m_ack = 0; m_started = 0; m_in_trap = 0;
  endtask

  // One architectural step, derived from the behaviour rules
  task automatic model_step(input bit l, input bit [1:0] s, input bit [31:0] t,
                            input bit [31:0] a, input bit an, input bit tr);
    logic [31:0] tgt;
    tgt = (s == 2'b01) ? t : a;
    if (!m_started) begin
      m_started = 1; m_fv = 1;
    end else if (m_in_trap) begin
      m_in_trap = 0; m_ack = 0;
    end else if (tr) begin
      m_spc = m_pc; m_snpc = m_npc;
      m_pc = 32'h80; m_npc = 32'h84; m_squash = 0; m_ack = 1; m_in_trap = 1;
    end else begin
      m_ack = 0;
      if (l) begin
        if (s == 2'b11) m_squash = 0;
        else if (s == 2'b00) begin
          m_pc = m_npc; m_npc = m_npc + 32'd4; m_squash = an;
        end else if (an) begin
          m_pc = tgt; m_npc = tgt + 32'd4; m_squash = 0;
        end else begin
          m_pc = m_npc; m_npc = tgt; m_squash = 0;
        end
      end
    end
  endtask

  // Drive inputs, take one clock edge, update the model, settle before checks
  task automatic step(input bit l, input bit [1:0] s, input bit [31:0] t,
                      input bit [31:0] a, input bit an, input bit tr);
    le = l; sel = s; ta = t; alu_out = a; annul = an; trap_req = tr;
    @(posedge clk);
    model_step(l, s, t, a, an, tr);
    #1;
  endtask

  task automatic clr_low();
    clr = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic clr_high();
    clr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    clr_low();
    total++;
    if ({pc, npc, squash, fetch_valid, trap_ack, saved_pc, saved_npc} !==
        {32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL reset32: pc=%h npc=%h sq=%b fv=%b ack=%b spc=%h snpc=%h want 0/4/0/0/0/0/0",
                      pc, npc, squash, fetch_valid, trap_ack, saved_pc, saved_npc);
    end
    total++;
    if ({pc8, npc8, squash8, fetch_valid8, trap_ack8} !== {8'h0, 8'h4, 3'b000}) begin
      bad++; $display("FAIL reset8: pc=%h npc=%h want 00/04", pc8, npc8);
    end
    clr_high();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_npc[3] = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 0, 0, 0, 0);
      total++;
      if ({pc, npc, fetch_valid} !== {exp_pc[i], exp_npc[i], 1'b1}) begin
        bad++; $display("FAIL seq[%0d]: pc=%h npc=%h fv=%b want %h %h 1",
                        i, pc, npc, fetch_valid, exp_pc[i], exp_npc[i]);
      end
    end
  endtask

  task automatic test_branch();
    step(1, 2'b01, 32'h40, 0, 0, 0);
    total++;
    if ({pc, npc} !== {32'hC, 32'h40}) begin
      bad++; $display("FAIL branch_ta: pc=%h npc=%h want c 40", pc, npc);
    end
    step(1, 2'b00, 0, 0, 0, 0);
    total++;
    if ({pc, npc} !== {32'h40, 32'h44}) begin
      bad++; $display("FAIL branch_seq: pc=%h npc=%h want 40 44", pc, npc);
    end
  endtask

  task automatic test_annul();
    clr_low(); clr_high();
    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 1, 0);
    total++;
    if ({pc, npc, squash} !== {32'hC, 32'h10, 1'b1}) begin
      bad++; $display("FAIL annul_untaken: pc=%h npc=%h sq=%b want c 10 1", pc, npc, squash);
    end
    step(1, 2'b10, 0, 32'h100, 1, 0);
    total++;
    if ({pc, npc, squash} !== {32'h100, 32'h104, 1'b0}) begin
      bad++; $display("FAIL annul_taken: pc=%h npc=%h sq=%b want 100 104 0", pc, npc, squash);
    end
    step(1, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 0, 0, 1, 0);
    total++;
    if ({pc, npc, squash} !== {32'h104, 32'h108, 1'b0}) begin
      bad++; $display("FAIL annul_hold: pc=%h npc=%h sq=%b want 104 108 0", pc, npc, squash);
    end
  endtask

  task automatic test_stall_trap();
    logic [31:0] p0, n0;
    p0 = m_pc; n0 = m_npc;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b01, 32'hDEAD0, 0, 0, 0);
      total++;
      if ({pc, npc} !== {p0, n0}) begin
        bad++; $display("FAIL stall[%0d]: pc=%h npc=%h want %h %h", i, pc, npc, p0, n0);
      end
    end
    step(0, 2'b01, 32'h300, 0, 1, 1);
    total++;
    if ({pc, npc, saved_pc, saved_npc, trap_ack, squash} !== {32'h80, 32'h84, p0, n0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL trap_entry: pc=%h npc=%h spc=%h snpc=%h ack=%b want 80 84 %h %h 1",
                      pc, npc, saved_pc, saved_npc, trap_ack, p0, n0);
    end
    // trap_req held: TRAP cycle ignores it, then RUN re-traps
    step(1, 2'b01, 32'h300, 0, 0, 1);
    total++;
    if ({pc, npc, trap_ack, fetch_valid} !== {32'h80, 32'h84, 1'b0, 1'b1}) begin
      bad++; $display("FAIL trap_cycle: pc=%h npc=%h ack=%b fv=%b want 80 84 0 1",
                      pc, npc, trap_ack, fetch_valid);
    end
    step(1, 2'b01, 32'h300, 0, 0, 1);
    total++;
    if ({saved_pc, saved_npc, trap_ack} !== {32'h80, 32'h84, 1'b1}) begin
      bad++; $display("FAIL retrap: spc=%h snpc=%h ack=%b want 80 84 1", saved_pc, saved_npc, trap_ack);
    end
    step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    total++;
    if ({pc, npc, trap_ack} !== {32'h84, 32'h88, 1'b0}) begin
      bad++; $display("FAIL post_trap: pc=%h npc=%h ack=%b want 84 88 0", pc, npc, trap_ack);
    end
  endtask

  task automatic test_wrap();
    step(1, 2'b01, 32'hFC, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    total++;
    if ({pc8, npc8} !== {8'hFC, 8'h00}) begin
      bad++; $display("FAIL wrap8: pc=%h npc=%h want fc 00", pc8, npc8);
    end
    total++;
    if ({pc, npc} !== {32'hFC, 32'h100}) begin
      bad++; $display("FAIL wrap32: pc=%h npc=%h want fc 100", pc, npc);
    end
  endtask

  task automatic test_reset_in_trap();
    step(1, 2'b00, 0, 0, 0, 1);
    total++;
    if (trap_ack !== 1'b1) begin
      bad++; $display("FAIL trap_before_clr: ack=%b want 1", trap_ack);
    end
    #2;
    clr_low();
    total++;
    if ({pc, npc, squash, fetch_valid, trap_ack, saved_pc, saved_npc} !==
        {32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL async_clr: pc=%h npc=%h fv=%b ack=%b spc=%h snpc=%h want reset values",
                      pc, npc, fetch_valid, trap_ack, saved_pc, saved_npc);
    end
    clr_high();
    step(1, 2'b01, 32'h500, 0, 0, 1);
    total++;
    if ({pc, npc, fetch_valid, trap_ack} !== {32'h0, 32'h4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL init_after_clr: pc=%h npc=%h fv=%b ack=%b want 0 4 1 0",
                      pc, npc, fetch_valid, trap_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      total++;
      if ({pc, npc, squash, fetch_valid, trap_ack, saved_pc, saved_npc} !==
          {m_pc, m_npc, m_squash, m_fv, m_ack, m_spc, m_snpc}) begin
        bad++; $display("FAIL rand32[%0d]: pc=%h npc=%h sq=%b ack=%b spc=%h snpc=%h want %h %h %b %b %h %h",
                        i, pc, npc, squash, trap_ack, saved_pc, saved_npc,
                        m_pc, m_npc, m_squash, m_ack, m_spc, m_snpc);
      end
      total++;
      if ({pc8, npc8, squash8, fetch_valid8, trap_ack8, saved_pc8, saved_npc8} !==
          {m_pc[7:0], m_npc[7:0], m_squash, m_fv, m_ack, m_spc[7:0], m_snpc[7:0]}) begin
        bad++; $display("FAIL rand8[%0d]: pc=%h npc=%h spc=%h snpc=%h want %h %h %h %h",
                        i, pc8, npc8, saved_pc8, saved_npc8,
                        m_pc[7:0], m_npc[7:0], m_spc[7:0], m_snpc[7:0]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_annul();
    test_stall_trap();
    test_wrap();
    test_reset_in_trap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_npc_sequencer.md
PC_NPC_SEQUENCER -- requirements
Module: pc_npc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address width of all PC-related buses.
REQ-002 The block SHALL have parameter INC, default 4, giving the sequential instruction increment.
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-004 The block SHALL have parameter TRAP_VEC, default 'h80, giving the PC value loaded on trap entry.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port le, input, 1 bit: load enable; 0 means pipeline stall.
REQ-008 The block SHALL have port sel, input, 2 bits: 00 sequential, 01 TA, 10 ALU_OUT, 11 hold.
REQ-009 The block SHALL have port ta, input, WIDTH bits: branch/call target address.
REQ-010 The block SHALL have port alu_out, input, WIDTH bits: jmpl target address.
REQ-011 The block SHALL have port annul, input, 1 bit: annul bit of the current control-transfer instruction.
REQ-012 The block SHALL have port trap_req, input, 1 bit: trap request, level-sensitive.
REQ-013 The block SHALL have port pc, output, WIDTH bits: current program counter.
REQ-014 The block SHALL have port npc, output, WIDTH bits: next program counter.
REQ-015 The block SHALL have port squash, output, 1 bit: instruction at pc is annulled and must not execute.
REQ-016 The block SHALL have port fetch_valid, output, 1 bit: pc is a valid fetch address.
REQ-017 The block SHALL have ports saved_pc and saved_npc, outputs, WIDTH bits each: pc and npc captured at trap entry.
REQ-018 The block SHALL have port trap_ack, output, 1 bit: one-cycle pulse on trap entry.

Function
REQ-019 The FSM SHALL have three states: INIT, RUN and TRAP.
REQ-020 INIT SHALL last exactly one cycle, ignoring all inputs, then go to RUN.
REQ-021 fetch_valid SHALL be 0 in INIT and 1 in RUN and TRAP.
REQ-022 In RUN with le=1, trap_req=0, annul=0, the sequencer SHALL update one cycle after the edge: sel=00 pc<=npc, npc<=npc+INC; sel=01 pc<=npc, npc<=ta; sel=10 pc<=npc, npc<=alu_out; sel=11 pc and npc hold.
REQ-023 In RUN with le=1, annul=1, sel=00 (untaken annulled branch), it SHALL set pc<=npc, npc<=npc+INC, squash<=1.
REQ-024 In RUN with le=1, annul=1, sel=01 or 10 (taken annulled, delay slot skipped), it SHALL set pc<=target, npc<=target+INC, squash<=0.
REQ-025 annul SHALL be ignored when sel=11.
REQ-026 squash SHALL be registered and clear on the next le=1 cycle in which REQ-023 does not apply.
REQ-027 With le=0 and trap_req=0, pc, npc, squash, saved_pc and saved_npc SHALL all hold.
REQ-028 trap_req=1 in RUN SHALL take priority over le, sel and annul.
REQ-029 On trap entry the sequencer SHALL set saved_pc<=pc, saved_npc<=npc, pc<=TRAP_VEC, npc<=TRAP_VEC+INC, squash<=0, trap_ack<=1, and go to TRAP.
REQ-030 TRAP SHALL last one cycle, ignore trap_req, sel, annul and le, clear trap_ack, then go to RUN; a still-asserted trap_req SHALL re-trap in RUN.
REQ-031 trap_req SHALL be ignored in INIT.
REQ-032 All additions SHALL be modulo 2^WIDTH, wrapping silently with no flag.
REQ-033 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-034 With clr=0, immediately and independent of clk, the block SHALL set state=INIT, pc=RESET_PC, npc=RESET_PC+INC, squash=0, fetch_valid=0, trap_ack=0, saved_pc=0, saved_npc=0.
REQ-035 Reset asserted mid-trap or mid-stall SHALL abandon the operation and apply REQ-034.
REQ-036 After clr rises, the first state-changing edge SHALL be the INIT->RUN transition.

Verification
REQ-037 Reset release, then 3 cycles with le=1, sel=00 -> fetch_valid 0 then 1; pc sequence 0, 0, 4, 8 and npc sequence 4, 4, 8, 12.
REQ-038 At pc=8, npc=12, sel=01, ta=0x40 -> pc=12, npc=0x40; next cycle with sel=00 -> pc=0x40, npc=0x44.
REQ-039 At pc=8, npc=12: annul=1, sel=00 -> pc=12, squash=1; annul=1, sel=10, alu_out=0x100 -> pc=0x100, npc=0x104, squash=0.
REQ-040 With le=0 and sel=01 for 3 cycles -> pc and npc unchanged; trap_req=1 with le=0 -> pc=0x80, npc=0x84, saved_pc and saved_npc equal the prior pc and npc, trap_ack high for exactly 1 cycle.
REQ-041 With WIDTH=8 and npc=0xFC, sel=00 -> npc wraps to 0x00.
REQ-042 clr pulsed low asynchronously during TRAP -> all outputs show reset values before the next clk edge.
